// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundle of request/data/grant signals between four requesters and the
// round-robin arbiter that owns the shared 4:1 mux.
//   req      : request vector, req[i] high while requester i wants the mux
//   d0..d3   : data inputs of requesters 0..3 (DATA_W bits each)
//   gnt      : one-hot registered grant, zero when idle
//   sel      : mux select of the current owner
//   busy     : high while any grant is active
//   z, z_vld : registered mux output and its valid flag
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 1
);
    logic [3:0]        req;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic              busy;
    logic [DATA_W-1:0] z;
    logic              z_vld;

    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, busy, z, z_vld
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, busy, z, z_vld
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4:1 mux among four requesters. One owner at
// a time, each tenure bounded to MAX_HOLD consecutive cycles, after which the
// grant rotates to the next requester in pointer order (or back to the owner
// if nobody else is asking). The selected data is registered as z/z_vld.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave (req, d0..d3 in; gnt, sel, busy, z, z_vld out)
// Parameters:
//   DATA_W   : width of d0..d3 and z
//   MAX_HOLD : maximum consecutive grant cycles per tenure (>= 1)
// Configuration macro:
//   MUX_ARB_PRIO0_EN : when defined, requester 0 wins every arbitration point
//                      it takes part in (no mid-tenure preemption; a forced
//                      rotation still moves away from an owning requester 0
//                      when others request).
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst_n,
    mux4_rr_arbiter_if.slave  bus
);

    localparam int                CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [3:0]        gnt_r, gnt_s;
    logic [1:0]        sel_r, sel_s;
    logic              busy_r, busy_s;
    logic [CNT_W-1:0]  hold_r, hold_s;
    logic [1:0]        ptr_r, ptr_s;
    logic [DATA_W-1:0] z_r;
    logic              z_vld_r;

    logic [3:0]        owner_oh_s;
    logic              owner_req_s;
    logic [3:0]        cand_s;
    logic [2:0]        pick_s;
    logic              arb_s;

    // One-hot decode of a 2-bit requester index.
    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin search ptr+1, ptr+2, ptr+3, ptr; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!res[2] && cand[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection, optionally giving requester 0 absolute priority.
    function automatic logic [2:0] pick_winner(input logic [3:0] cand, input logic [1:0] ptr);
`ifdef MUX_ARB_PRIO0_EN
        if (cand[0]) begin
            return 3'b100;
        end else begin
            return rr_pick(cand, ptr);
        end
`else
        return rr_pick(cand, ptr);
`endif
    endfunction

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        sel_s       = sel_r;
        busy_s      = busy_r;
        hold_s      = hold_r;
        ptr_s       = ptr_r;
        owner_oh_s  = to_onehot(sel_r);
        owner_req_s = |(bus.req & owner_oh_s);
        cand_s      = bus.req;
        pick_s      = 3'b000;
        arb_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    arb_s  = 1'b1;
                    pick_s = pick_winner(bus.req, ptr_r);
                end else begin
                    gnt_s  = 4'b0000;
                    busy_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (owner_req_s && (hold_r < MAX_HOLD_C)) begin
                    hold_s = hold_r + CNT_W'(1);
                end else begin
                    arb_s = 1'b1;
                    ptr_s = sel_r;
                    // Forced rotation skips the owner unless it is the only requester.
                    if (owner_req_s && (|(bus.req & ~owner_oh_s))) begin
                        cand_s = bus.req & ~owner_oh_s;
                    end else begin
                        cand_s = bus.req;
                    end
                    pick_s = pick_winner(cand_s, sel_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
                hold_s  = {CNT_W{1'b0}};
            end
        endcase

        if (arb_s) begin
            if (pick_s[2]) begin
                state_s = ST_GRANT;
                gnt_s   = to_onehot(pick_s[1:0]);
                sel_s   = pick_s[1:0];
                busy_s  = 1'b1;
                hold_s  = CNT_W'(1);
            end else begin
                // sel intentionally keeps the last owner.
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
                hold_s  = {CNT_W{1'b0}};
            end
        end else begin
            state_s = state_s;
        end
    end

    // FSM state, grant outputs, hold counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            busy_r  <= 1'b0;
            hold_r  <= {CNT_W{1'b0}};
            ptr_r   <= 2'd3;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
            hold_r  <= hold_s;
            ptr_r   <= ptr_s;
        end
    end

    // Shared mux datapath: registers the owner's data one cycle behind gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_r     <= {DATA_W{1'b0}};
            z_vld_r <= 1'b0;
        end else if (busy_r) begin
            case (sel_r)
                2'd0:    z_r <= bus.d0;
                2'd1:    z_r <= bus.d1;
                2'd2:    z_r <= bus.d2;
                2'd3:    z_r <= bus.d3;
                default: z_r <= {DATA_W{1'b0}};
            endcase
            z_vld_r <= 1'b1;
        end else begin
            z_r     <= {DATA_W{1'b0}};
            z_vld_r <= 1'b0;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.sel   = sel_r;
    assign bus.busy  = busy_r;
    assign bus.z     = z_r;
    assign bus.z_vld = z_vld_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed scenarios plus randomized traffic for mux4_rr_arbiter, checked
// against a behavioural model that tracks owner / tenure length / last owner
// as plain integers.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 1;
    localparam int MAX_HOLD = 8;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req_v;
    logic [DATA_W-1:0] dv [4];

    int tests_run;
    int tests_failed;

    // Reference model state
    int                m_owner;   // -1 when idle
    int                m_held;    // cycles granted in current tenure
    int                m_last;    // last owner index
    int                m_sel;
    logic [DATA_W-1:0] m_z;
    logic              m_zv;

    mux4_rr_arbiter_if #(.DATA_W(DATA_W)) ifc ();

    assign ifc.req = req_v;
    assign ifc.d0  = dv[0];
    assign ifc.d1  = dv[1];
    assign ifc.d2  = dv[2];
    assign ifc.d3  = dv[3];

    mux4_rr_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pick a winner among requesters in r, starting after 'last'; 'excl' is
    // skipped unless it is the only requester.
    function automatic int choose(input logic [3:0] r, input int last, input int excl);
        int others;
        int i;
        others = 0;
        for (int k = 0; k < 4; k++) begin
            if (r[k] && k != excl) others++;
        end
`ifdef MUX_ARB_PRIO0_EN
        if (r[0] && !(excl == 0 && others > 0)) return 0;
`endif
        for (int k = 1; k <= 4; k++) begin
            i = (last + k) % 4;
            if (r[i] && !(i == excl && others > 0)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_sel   = 0;
        m_z     = '0;
        m_zv    = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        if (m_owner >= 0) begin
            m_z  = dv[m_sel];
            m_zv = 1'b1;
        end else begin
            m_z  = '0;
            m_zv = 1'b0;
        end
        if (m_owner < 0) begin
            if (req_v != 4'b0000) begin
                w = choose(req_v, m_last, -1);
                m_owner = w; m_held = 1; m_sel = w;
            end
        end else if (req_v[m_owner] && m_held < MAX_HOLD) begin
            m_held++;
        end else begin
            m_last = m_owner;
            w = choose(req_v, m_last, req_v[m_owner] ? m_owner : -1);
            if (w >= 0) begin
                m_owner = w; m_held = 1; m_sel = w;
            end else begin
                m_owner = -1; m_held = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_v = 4'b0000;
        for (int k = 0; k < 4; k++) dv[k] = '0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_v = 4'b1111;
        @(posedge clk);
        #1;
        tests_run++;
        if (ifc.gnt !== 4'b0000 || ifc.sel !== 2'b00 || ifc.busy !== 1'b0 ||
            ifc.z !== '0 || ifc.z_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: gnt=%b sel=%b busy=%b z=%b z_vld=%b, want all zero",
                     ifc.gnt, ifc.sel, ifc.busy, ifc.z, ifc.z_vld);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_v = 4'b0001;
        dv[0] = 1'b1;
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0001 || ifc.sel !== 2'b00 || ifc.busy !== 1'b1 || ifc.z_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: gnt=%b sel=%b busy=%b z_vld=%b, want 0001 00 1 0",
                     ifc.gnt, ifc.sel, ifc.busy, ifc.z_vld);
        end
        step();
        tests_run++;
        if (ifc.z !== 1'b1 || ifc.z_vld !== 1'b1 || ifc.gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_data: z=%b z_vld=%b gnt=%b, want 1 1 0001",
                     ifc.z, ifc.z_vld, ifc.gnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        do_reset();
        req_v = 4'b1111;
        for (int i = 0; i < 4 * MAX_HOLD + 1; i++) begin
            step();
            exp = 4'b0001 << ((i / MAX_HOLD) % 4);
            tests_run++;
            if (ifc.gnt !== exp || ifc.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rotation cycle %0d: gnt=%b busy=%b, want %b 1",
                         i, ifc.gnt, ifc.busy, exp);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        req_v = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (ifc.gnt !== 4'b0001) begin
                tests_failed++;
                $display("FAIL drop_hold cycle %0d: gnt=%b, want 0001", i, ifc.gnt);
            end
        end
        req_v = 4'b0100;
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0100 || ifc.busy !== 1'b1 || ifc.sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL drop_handover: gnt=%b busy=%b sel=%b, want 0100 1 10",
                     ifc.gnt, ifc.busy, ifc.sel);
        end
    endtask

    task automatic test_sole();
        do_reset();
        req_v = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if (ifc.gnt !== 4'b0010 || ifc.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL sole_owner cycle %0d: gnt=%b busy=%b, want 0010 1",
                         i, ifc.gnt, ifc.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_v = 4'b1111;
        for (int k = 0; k < 4; k++) dv[k] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ifc.gnt !== 4'b0000 || ifc.busy !== 1'b0 || ifc.z !== '0 ||
            ifc.z_vld !== 1'b0 || ifc.sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid: gnt=%b busy=%b z=%b z_vld=%b sel=%b, want all zero",
                     ifc.gnt, ifc.busy, ifc.z, ifc.z_vld, ifc.sel);
        end
        model_reset();
        req_v = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant: gnt=%b, want 0001", ifc.gnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        req_v = 4'b0100;
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL prio_owner2: gnt=%b, want 0100", ifc.gnt);
        end
        req_v = 4'b0111;
        step();
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL prio_no_preempt: gnt=%b, want 0100", ifc.gnt);
        end
        req_v = 4'b0011;
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL prio_release: gnt=%b, want 0001", ifc.gnt);
        end

        do_reset();
        req_v = 4'b0011;
        for (int i = 0; i < MAX_HOLD; i++) step();
        tests_run++;
        if (ifc.gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL forced_hold: gnt=%b, want 0001", ifc.gnt);
        end
        step();
        tests_run++;
        if (ifc.gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL forced_rotate: gnt=%b, want 0010", ifc.gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3, 0) == 0) req_v = 4'($urandom_range(15, 0));
            for (int k = 0; k < 4; k++) dv[k] = DATA_W'($urandom);
            step();
            eg = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
            tests_run++;
            if (ifc.gnt !== eg || ifc.sel !== 2'(m_sel) || ifc.busy !== (m_owner >= 0) ||
                ifc.z !== m_z || ifc.z_vld !== m_zv) begin
                tests_failed++;
                $display("FAIL random cycle %0d: gnt=%b sel=%0d busy=%b z=%b z_vld=%b, want %b %0d %b %b %b",
                         i, ifc.gnt, ifc.sel, ifc.busy, ifc.z, ifc.z_vld,
                         eg, m_sel, (m_owner >= 0), m_z, m_zv);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_v        = 4'b0000;
        for (int k = 0; k < 4; k++) dv[k] = '0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_sole();
        test_reset_mid();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
